memory_controller: RTL and testbench

- Shares the single byte-wide RAM/IO port between the instruction fetcher (IF, word reads) and the LoadStoreBuffer (LSB, 1/2/4-byte reads and writes).
- Latches each requester's one-cycle request pulse, arbitrates round-robin, sequences byte transfers little-endian, and returns a one-cycle ready pulse with the assembled data.
- Aborts speculative reads on rollback. Stalls IO writes while the IO buffer is full.

---
 rtl/memory_controller_pkg.sv | 34 +++
 rtl/memory_controller_if.sv | 39 +++
 rtl/memory_controller_request_slot.sv | 50 +++++
 rtl/memory_controller.sv | 150 +++++++++++++++
 tb/tb_memory_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the byte-wide RAM/IO port arbiter.
// Goal codes are byte counts; any undefined code falls back to a full word.
package memory_controller_pkg;

  localparam int         ADDR_WIDTH = 32;
  localparam logic [1:0] MC_IO_SEL  = 2'b11;

  localparam logic [2:0] GOAL_B = 3'd1;
  localparam logic [2:0] GOAL_H = 3'd2;
  localparam logic [2:0] GOAL_W = 3'd4;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw;
    logic [2:0]            goal;
    logic [31:0]           data;
  } mc_req_t;

  function automatic logic [2:0] goal_len(input logic [2:0] goal);
    logic [2:0] n;
    case (goal)
      GOAL_B, GOAL_H, 3'd3: n = goal;
      default:              n = GOAL_W;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Request/response and RAM bus signals of the memory controller.
// The controller takes the slave view; the surrounding CPU/RAM take the master view.
interface memory_controller_if;

  logic                                      rollback_in;
  logic                                      if_request_in;
  logic [memory_controller_pkg::ADDR_WIDTH-1:0] if_address_in;
  logic                                      if_ready_out;
  logic [31:0]                               if_data_out;
  logic                                      lsb_request_in;
  logic                                      lsb_rw_signal_in;
  logic [memory_controller_pkg::ADDR_WIDTH-1:0] lsb_address_in;
  logic [2:0]                                lsb_goal_in;
  logic [31:0]                               lsb_data_in;
  logic                                      lsb_ready_out;
  logic [31:0]                               lsb_data_out;
  logic [7:0]                                ram_data_in;
  logic                                      ram_rw_out;
  logic [memory_controller_pkg::ADDR_WIDTH-1:0] ram_address_out;
  logic [7:0]                                ram_data_out;
  logic                                      io_buffer_full_in;

  modport slave (
    input  rollback_in, if_request_in, if_address_in,
    input  lsb_request_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
    input  ram_data_in, io_buffer_full_in,
    output if_ready_out, if_data_out, lsb_ready_out, lsb_data_out,
    output ram_rw_out, ram_address_out, ram_data_out
  );

  modport master (
    output rollback_in, if_request_in, if_address_in,
    output lsb_request_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
    output ram_data_in, io_buffer_full_in,
    input  if_ready_out, if_data_out, lsb_ready_out, lsb_data_out,
    input  ram_rw_out, ram_address_out, ram_data_out
  );

endinterface

// File: rtl/memory_controller_request_slot.sv
// One pending-request latch. An incoming pulse is visible the same cycle so an
// idle controller can grant it without a bubble; rollback drops reads, never writes.
module mc_request_slot
  import memory_controller_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_i,
  input  mc_req_t req_data_i,
  input  logic    kill_read_i,
  input  logic    take_i,
  output logic    valid_o,
  output mc_req_t slot_o
);

  logic    full_q, full_d;
  mc_req_t slot_q, slot_d;
  logic    in_ok_s, held_ok_s;

  assign in_ok_s   = req_i & ~(kill_read_i & ~req_data_i.rw);
  assign held_ok_s = full_q & ~(kill_read_i & ~slot_q.rw);
  assign valid_o   = in_ok_s | held_ok_s;
  assign slot_o    = in_ok_s ? req_data_i : slot_q;

  // Next slot state: a grant consumes whatever is visible, a new pulse overwrites
  always_comb begin
    full_d = held_ok_s;
    slot_d = slot_q;
    if (take_i) begin
      full_d = 1'b0;
    end else if (in_ok_s) begin
      full_d = 1'b1;
      slot_d = req_data_i;
    end else begin
      full_d = held_ok_s;
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      slot_q <= '0;
    end else begin
      full_q <= full_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Round-robin arbiter and little-endian byte sequencer sharing one byte-wide
// RAM/IO port between the instruction fetcher and the load/store buffer.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter logic [1:0] IO_SEL = MC_IO_SEL
) (
  input logic                clk,
  input logic                rst_n,
  memory_controller_if.slave bus
);

  mc_state_e             state_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [31:0]           wdata_q, asm_q, asm_s, if_data_q, lsb_data_q;
  logic [2:0]            n_q, k_q;
  logic [1:0]            byte_idx_s;
  logic                  gnt_if_q, last_if_q, if_ready_q, lsb_ready_q;
  mc_req_t               if_in_s, lsb_in_s, if_slot_s, lsb_slot_s, act_s;
  logic                  if_valid_s, lsb_valid_s, grant_if_s, grant_lsb_s;
  logic                  can_grant_s, take_if_s, take_lsb_s;
  logic                  stall_s, rd_done_s, wr_done_s;

  assign if_in_s  = '{addr: bus.if_address_in, rw: 1'b0, goal: GOAL_W, data: 32'd0};
  assign lsb_in_s = '{addr: bus.lsb_address_in, rw: bus.lsb_rw_signal_in,
                      goal: bus.lsb_goal_in, data: bus.lsb_data_in};

  mc_request_slot u_if_slot (
    .clk(clk), .rst_n(rst_n), .req_i(bus.if_request_in), .req_data_i(if_in_s),
    .kill_read_i(bus.rollback_in), .take_i(take_if_s),
    .valid_o(if_valid_s), .slot_o(if_slot_s)
  );

  mc_request_slot u_lsb_slot (
    .clk(clk), .rst_n(rst_n), .req_i(bus.lsb_request_in), .req_data_i(lsb_in_s),
    .kill_read_i(bus.rollback_in), .take_i(take_lsb_s),
    .valid_o(lsb_valid_s), .slot_o(lsb_slot_s)
  );

  // On contention the requester that was not served last wins
  assign grant_if_s  = if_valid_s & (~lsb_valid_s | ~last_if_q);
  assign grant_lsb_s = lsb_valid_s & ~grant_if_s;
  assign act_s       = grant_if_s ? if_slot_s : lsb_slot_s;

  assign stall_s     = (state_q == MC_WRITE) && (addr_q[17:16] == IO_SEL) && bus.io_buffer_full_in;
  assign rd_done_s   = (state_q == MC_READ) && (k_q == n_q) && !bus.rollback_in;
  assign wr_done_s   = (state_q == MC_WRITE) && !stall_s && (k_q == n_q - 3'd1);
  assign can_grant_s = (state_q == MC_IDLE) || rd_done_s || wr_done_s;
  assign take_if_s   = can_grant_s & grant_if_s;
  assign take_lsb_s  = can_grant_s & grant_lsb_s;

  // Read data for byte k-1 arrives while address k is on the bus
  assign byte_idx_s = k_q[1:0] - 2'd1;

  // Assembly register with the byte arriving this cycle merged in
  always_comb begin
    asm_s = asm_q;
    if ((state_q == MC_READ) && (k_q != 3'd0)) begin
      asm_s[{byte_idx_s, 3'b000} +: 8] = bus.ram_data_in;
    end else begin
      asm_s = asm_q;
    end
  end

  // Controller FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MC_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      n_q         <= 3'd0;
      k_q         <= 3'd0;
      gnt_if_q    <= 1'b0;
      last_if_q   <= 1'b0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_data_q  <= 32'd0;
    end else begin
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      case (state_q)
        MC_READ: begin
          if (bus.rollback_in) begin
            state_q <= MC_IDLE;
            addr_q  <= '0;
          end else if (rd_done_s) begin
            state_q <= MC_IDLE;
            addr_q  <= '0;
            if (gnt_if_q) begin
              if_ready_q <= 1'b1;
              if_data_q  <= asm_s;
            end else begin
              lsb_ready_q <= 1'b1;
              lsb_data_q  <= asm_s;
            end
          end else begin
            asm_q  <= asm_s;
            k_q    <= k_q + 3'd1;
            addr_q <= (k_q + 3'd1 < n_q) ? base_q + {29'd0, k_q + 3'd1} : '0;
          end
        end
        MC_WRITE: begin
          if (stall_s) begin
            state_q <= MC_WRITE;
          end else if (wr_done_s) begin
            state_q     <= MC_IDLE;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            lsb_ready_q <= 1'b1;
          end else begin
            k_q     <= k_q + 3'd1;
            addr_q  <= addr_q + 32'd1;
            wdata_q <= {8'd0, wdata_q[31:8]};
          end
        end
        MC_IDLE: begin
          state_q <= MC_IDLE;
        end
        default: begin
          state_q <= MC_IDLE;
          addr_q  <= '0;
        end
      endcase
      // A finishing transfer hands the port straight to the next pending request
      if (can_grant_s && (grant_if_s || grant_lsb_s)) begin
        state_q   <= act_s.rw ? MC_WRITE : MC_READ;
        base_q    <= act_s.addr;
        addr_q    <= act_s.addr;
        n_q       <= goal_len(act_s.goal);
        k_q       <= 3'd0;
        wdata_q   <= act_s.rw ? act_s.data : 32'd0;
        asm_q     <= 32'd0;
        gnt_if_q  <= grant_if_s;
        last_if_q <= grant_if_s;
      end
    end
  end

  assign bus.if_ready_out    = if_ready_q;
  assign bus.if_data_out     = if_data_q;
  assign bus.lsb_ready_out   = lsb_ready_q;
  assign bus.lsb_data_out    = lsb_data_q;
  assign bus.ram_rw_out      = (state_q == MC_WRITE) && !stall_s;
  assign bus.ram_address_out = addr_q;
  assign bus.ram_data_out    = wdata_q[7:0];

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench: stimulus pushes expected bus beats and ready pulses,
// a negedge monitor pops and compares them as the controller produces them.
module tb_memory_controller;
  import memory_controller_pkg::*;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } bus_exp_t;

  typedef struct {
    logic        is_if;
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
  } rdy_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   t0;
  logic end_req = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  bus_exp_t bus_q[$];
  rdy_exp_t rdy_q[$];

  memory_controller_if bus ();

  memory_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_0040: return 8'h9A;
      default:       return 8'h00;
    endcase
  endfunction

  // Byte RAM: read data valid the cycle after its address
  always @(posedge clk) bus.ram_data_in <= ram_byte(bus.ram_address_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_chk = n_chk + 1;
    $display("FAIL %s: unexpected event, value 0x%08h (cycle %0d)", name, act, cyc);
  endtask

  task automatic take_ready(input logic is_if, input logic [31:0] data);
    rdy_exp_t e;
    if (rdy_q.size() == 0) begin
      unexpected(is_if ? "if_ready_extra" : "lsb_ready_extra", data);
    end else begin
      e = rdy_q.pop_front();
      check("ready_source", {31'd0, is_if}, {31'd0, e.is_if});
      if (e.chk_data) check("ready_data", data, e.data);
      if (e.cyc >= 0) check("ready_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: every comparison happens here
  always @(negedge clk) begin
    bus_exp_t b;
    if (!rst_n) begin
      check("rst_if_ready",  {31'd0, bus.if_ready_out}, 32'd0);
      check("rst_if_data",   bus.if_data_out, 32'd0);
      check("rst_lsb_ready", {31'd0, bus.lsb_ready_out}, 32'd0);
      check("rst_lsb_data",  bus.lsb_data_out, 32'd0);
      check("rst_ram_rw",    {31'd0, bus.ram_rw_out}, 32'd0);
      check("rst_ram_addr",  bus.ram_address_out, 32'd0);
      check("rst_ram_data",  {24'd0, bus.ram_data_out}, 32'd0);
    end else begin
      if (bus.ram_rw_out || (bus.ram_address_out != 32'd0)) begin
        if (bus_q.size() == 0) begin
          unexpected("bus_extra", bus.ram_address_out);
        end else begin
          b = bus_q.pop_front();
          check("bus_rw", {31'd0, bus.ram_rw_out}, {31'd0, b.rw});
          check("bus_addr", bus.ram_address_out, b.addr);
          if (b.rw) check("bus_wdata", {24'd0, bus.ram_data_out}, {24'd0, b.data});
          if (b.cyc >= 0) check("bus_cycle", 32'(cyc), 32'(b.cyc));
        end
      end
      if (bus.if_ready_out) take_ready(1'b1, bus.if_data_out);
      if (bus.lsb_ready_out) take_ready(1'b0, bus.lsb_data_out);
    end
    if (end_req) begin
      check("bus_beats_left", 32'(bus_q.size()), 32'd0);
      check("readies_left", 32'(rdy_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bus(input logic rw, input logic [31:0] a, input logic [7:0] d, input int c);
    bus_q.push_back('{rw, a, d, c});
  endtask

  task automatic exp_rdy(input logic is_if, input logic chk, input logic [31:0] d, input int c);
    rdy_q.push_back('{is_if, chk, d, c});
  endtask

  task automatic lsb_req(input logic rw, input logic [31:0] a, input logic [2:0] g, input logic [31:0] d);
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = rw;
    bus.lsb_address_in   = a;
    bus.lsb_goal_in      = g;
    bus.lsb_data_in      = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (bus_q.size() == 0 && rdy_q.size() == 0) break;
      tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rollback_in       = 1'b0;
    bus.if_request_in     = 1'b0;
    bus.if_address_in     = 32'd0;
    bus.lsb_request_in    = 1'b0;
    bus.lsb_rw_signal_in  = 1'b0;
    bus.lsb_address_in    = 32'd0;
    bus.lsb_goal_in       = 3'd0;
    bus.lsb_data_in       = 32'd0;
    bus.io_buffer_full_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // IF word read from idle
    t0 = cyc;
    bus.if_request_in = 1'b1;
    bus.if_address_in = 32'h0000_1000;
    for (int k = 0; k < 4; k++) exp_bus(1'b0, 32'h0000_1000 + 32'(k), 8'h00, t0 + 1 + k);
    exp_rdy(1'b1, 1'b1, 32'h0000_0513, t0 + 6);
    tick();
    bus.if_request_in = 1'b0;
    drain();

    // LSB halfword write
    t0 = cyc;
    lsb_req(1'b1, 32'h0000_2000, GOAL_H, 32'hABCD_1234);
    exp_bus(1'b1, 32'h0000_2000, 8'h34, t0 + 1);
    exp_bus(1'b1, 32'h0000_2001, 8'h12, t0 + 2);
    exp_rdy(1'b0, 1'b0, 32'd0, t0 + 3);
    tick();
    bus.lsb_request_in = 1'b0;
    drain();

    // Simultaneous IF and LSB byte read; last grant was LSB so IF goes first
    t0 = cyc;
    bus.if_request_in = 1'b1;
    bus.if_address_in = 32'h0000_1000;
    lsb_req(1'b0, 32'h0000_0040, GOAL_B, 32'd0);
    for (int k = 0; k < 4; k++) exp_bus(1'b0, 32'h0000_1000 + 32'(k), 8'h00, t0 + 1 + k);
    exp_bus(1'b0, 32'h0000_0040, 8'h00, -1);
    exp_rdy(1'b1, 1'b1, 32'h0000_0513, t0 + 6);
    exp_rdy(1'b0, 1'b1, 32'h0000_009A, -1);
    tick();
    bus.if_request_in  = 1'b0;
    bus.lsb_request_in = 1'b0;
    drain();

    // Rollback aborts the IF read; the queued IO write still completes
    t0 = cyc;
    bus.if_request_in = 1'b1;
    bus.if_address_in = 32'h0000_1000;
    for (int k = 0; k < 3; k++) exp_bus(1'b0, 32'h0000_1000 + 32'(k), 8'h00, t0 + 1 + k);
    exp_bus(1'b1, 32'h0003_0000, 8'hFF, -1);
    exp_rdy(1'b0, 1'b0, 32'd0, -1);
    tick();
    bus.if_request_in = 1'b0;
    lsb_req(1'b1, 32'h0003_0000, GOAL_B, 32'h0000_00FF);
    tick();
    bus.lsb_request_in = 1'b0;
    tick();
    bus.rollback_in = 1'b1;
    tick();
    bus.rollback_in = 1'b0;
    drain();

    // IO write held off for five cycles by a full IO buffer
    t0 = cyc;
    lsb_req(1'b1, 32'h0003_0000, GOAL_B, 32'h0000_005A);
    bus.io_buffer_full_in = 1'b1;
    for (int k = 1; k <= 5; k++) exp_bus(1'b0, 32'h0003_0000, 8'h00, t0 + k);
    exp_bus(1'b1, 32'h0003_0000, 8'h5A, t0 + 6);
    exp_rdy(1'b0, 1'b0, 32'd0, t0 + 7);
    tick();
    bus.lsb_request_in = 1'b0;
    repeat (5) tick();
    bus.io_buffer_full_in = 1'b0;
    drain();

    // Reset in the middle of a word write: nothing resumes afterwards
    t0 = cyc;
    lsb_req(1'b1, 32'h0000_5000, GOAL_W, 32'h1122_3344);
    exp_bus(1'b1, 32'h0000_5000, 8'h44, t0 + 1);
    exp_bus(1'b1, 32'h0000_5001, 8'h33, t0 + 2);
    tick();
    bus.lsb_request_in = 1'b0;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();

    end_req = 1'b1;
  end

endmodule
